// File: rtl/conv_mode_sequencer.sv
// rtl/conv_mode_sequencer.sv - steps the convolution mode select, captures results, streams them out
// Four modes are each given a settle window, then a bounded wait for ans; the 16 words then drain over valid/ready.
module conv_mode_sequencer #(
  parameter int DW      = 9,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [1:0]    m_out,
  input  logic          conv_ans,
  input  logic [DW-1:0] conv_out0,
  input  logic [DW-1:0] conv_out1,
  input  logic [DW-1:0] conv_out2,
  input  logic [DW-1:0] conv_out3,
  output logic          busy,
  output logic          done,
  output logic [3:0]    err,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [3:0]    res_tag
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [9:0] TO_LAST    = 10'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [1:0]    r_mode;
  logic [3:0]    r_scnt;
  logic [9:0]    r_timer;
  logic [3:0]    r_idx;
  logic [DW-1:0] r_buf [16];
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_err;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [3:0]    r_tag;

  logic w_timeout;
  logic w_xfer;

  assign w_timeout = (r_timer == TO_LAST);
  assign w_xfer    = r_valid && res_ready;

  assign m_out     = r_mode;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_tag   = r_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'd0;
      r_scnt  <= 4'd0;
      r_timer <= 10'd0;
      r_idx   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 4'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_mode  <= 2'd0;
            r_scnt  <= SETTLE_CNT;
            r_err   <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        // ans is deliberately not looked at here so a stale flag from the previous mode is dropped
        ST_SETTLE: begin
          r_scnt <= r_scnt - 4'd1;
          if (r_scnt == 4'd1) begin
            r_state <= ST_WAIT;
            r_timer <= 10'd0;
          end
        end
        ST_WAIT: begin
          if (conv_ans || w_timeout) begin
            if (conv_ans) begin
              r_buf[{r_mode, 2'd0}] <= conv_out0;
              r_buf[{r_mode, 2'd1}] <= conv_out1;
              r_buf[{r_mode, 2'd2}] <= conv_out2;
              r_buf[{r_mode, 2'd3}] <= conv_out3;
            end else begin
              r_buf[{r_mode, 2'd0}] <= '0;
              r_buf[{r_mode, 2'd1}] <= '0;
              r_buf[{r_mode, 2'd2}] <= '0;
              r_buf[{r_mode, 2'd3}] <= '0;
              r_err[r_mode]         <= 1'b1;
            end
            if (r_mode == 2'd3) begin
              r_state <= ST_STREAM;
              r_idx   <= 4'd0;
            end else begin
              r_mode  <= r_mode + 2'd1;
              r_state <= ST_SETTLE;
              r_scnt  <= SETTLE_CNT;
            end
          end else begin
            r_timer <= r_timer + 10'd1;
          end
        end
        // First STREAM cycle preloads word 0; afterwards each transfer loads the next word with no bubble
        ST_STREAM: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= r_buf[r_idx];
            r_tag   <= r_idx;
          end else if (w_xfer) begin
            if (r_idx == 4'd15) begin
              r_valid <= 1'b0;
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_mode  <= 2'd0;
            end else begin
              r_idx  <= r_idx + 4'd1;
              r_data <= r_buf[r_idx + 4'd1];
              r_tag  <= r_idx + 4'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mode_sequencer.sv
// tb/tb_conv_mode_sequencer.sv - directed bench with a schedule/scoreboard model for conv_mode_sequencer
module tb_conv_mode_sequencer;
  localparam int DW      = 9;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    m_out;
  logic          conv_ans;
  logic [DW-1:0] conv_out0, conv_out1, conv_out2, conv_out3;
  logic          busy, done, res_valid, res_ready;
  logic [3:0]    err, res_tag;
  logic [DW-1:0] res_data;

  always #5 clk = ~clk;

  conv_mode_sequencer #(.DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .m_out(m_out), .conv_ans(conv_ans),
    .conv_out0(conv_out0), .conv_out1(conv_out1), .conv_out2(conv_out2), .conv_out3(conv_out3),
    .busy(busy), .done(done), .err(err), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // stimulus configuration
  bit            ans_on [4];
  int            stale_mode = -1;
  logic [3:0]    ready_pat = 4'b1111;
  logic [DW-1:0] xmask = '0;
  int            mcnt = 0;
  logic [1:0]    prev_m = 2'd0;
  int            busy_start_c = -1;
  bit            start_in_done = 1'b0;
  int            stop_tag = -1;

  // model: mode schedule boundaries and expected stream
  int            bnd [5];
  int            first_valid;
  logic [DW-1:0] q_data [$];
  logic [3:0]    q_tag [$];
  logic [3:0]    exp_err;
  bit            model_active = 1'b0;
  int            t0 = 0;
  int            gcyc = 0;
  int            pops = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [DW-1:0] val(input int k, input int n);
    return DW'(16 * k + n) ^ xmask;
  endfunction

  function automatic int exp_mode(input int c);
    for (int k = 3; k >= 1; k--) if (c >= bnd[k]) return k;
    return 0;
  endfunction

  task automatic build_model();
    bnd[0] = 0;
    exp_err = 4'd0;
    q_data.delete();
    q_tag.delete();
    for (int k = 0; k < 4; k++) begin
      bnd[k+1] = bnd[k] + SETTLE + (ans_on[k] ? 1 : TIMEOUT);
      if (!ans_on[k]) exp_err[k] = 1'b1;
      for (int n = 0; n < 4; n++) begin
        q_data.push_back(ans_on[k] ? val(k, n) : '0);
        q_tag.push_back(4'(4 * k + n));
      end
    end
    first_valid = bnd[4] + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (m_out != prev_m) mcnt = 0; else mcnt++;
    prev_m    = m_out;
    conv_ans  = ans_on[m_out] || (stale_mode == int'(m_out) && mcnt < SETTLE);
    conv_out0 = val(int'(m_out), 0);
    conv_out1 = val(int'(m_out), 1);
    conv_out2 = val(int'(m_out), 2);
    conv_out3 = val(int'(m_out), 3);
    res_ready = ready_pat[gcyc % 4];
  endtask

  always @(negedge clk) begin
    if (model_active) begin
      int c;
      c = gcyc - t0;
      if (c < first_valid) begin
        chk("m_out_seq", m_out, exp_mode(c));
        chk("busy_run", busy, 1);
        chk("valid_early", res_valid, 0);
        chk("done_early", done, 0);
      end else if (q_data.size() > 0) begin
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, q_data[0]);
        chk("res_tag", res_tag, q_tag[0]);
        chk("m_out_stream", m_out, 3);
        chk("done_stream", done, 0);
        if (res_valid && res_ready) begin
          void'(q_data.pop_front());
          void'(q_tag.pop_front());
          pops++;
        end
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("valid_done", res_valid, 0);
        chk("m_out_done", m_out, 0);
        chk("err_flags", err, exp_err);
        model_active = 1'b0;
      end
    end
  end

  task automatic run();
    int n;
    build_model();
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = gcyc;
    pops = 0;
    model_active = 1'b1;
    n = 0;
    while (model_active && n < 3000) begin
      step();
      n++;
      start = 1'b0;
      if (gcyc - t0 == busy_start_c) start = 1'b1;
      if (done && start_in_done) start = 1'b1;
      if (stop_tag >= 0 && res_valid && int'(res_tag) == stop_tag) begin
        model_active = 1'b0;
        break;
      end
    end
    if (model_active) begin
      chk("run_bound", 0, 1);
      model_active = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk({name, "_busy"}, busy, 0);
      chk({name, "_valid"}, res_valid, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_m_out"}, m_out, 0);
    end
  endtask

  task automatic set_ans(input bit a0, input bit a1, input bit a2, input bit a3);
    ans_on[0] = a0; ans_on[1] = a1; ans_on[2] = a2; ans_on[3] = a3;
  endtask

  initial begin
    int nz;
    rst = 1'b1; start = 1'b0; conv_ans = 1'b0; res_ready = 1'b0;
    conv_out0 = '0; conv_out1 = '0; conv_out2 = '0; conv_out3 = '0;
    set_ans(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_out", m_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_tag", res_tag, 0);
    rst = 1'b0;
    idle_check("idle_after_rst", 3);

    // normal run
    set_ans(1, 1, 1, 1);
    xmask = '0;
    ready_pat = 4'b1111;
    build_model();
    chk("pin_first_valid", first_valid, 13);
    chk("pin_word8", q_data[8], 32);
    chk("pin_word15", q_data[15], 51);
    run();
    chk("normal_pops", pops, 16);
    idle_check("post_normal", 2);

    // timeout on mode 2
    set_ans(1, 1, 0, 1);
    xmask = 9'h0A5;
    build_model();
    chk("pin_mode2_len", bnd[3] - bnd[2], SETTLE + 255);
    chk("pin_err_to", exp_err, 4'b0100);
    chk("pin_word9_zero", q_data[9], 0);
    run();
    chk("timeout_pops", pops, 16);
    idle_check("post_timeout", 2);

    // backpressure, plus a start in the DONE cycle
    set_ans(1, 1, 1, 1);
    xmask = 9'h155;
    ready_pat = 4'b1001;
    start_in_done = 1'b1;
    run();
    chk("bp_pops", pops, 16);
    start_in_done = 1'b0;
    idle_check("post_done_start", 4);

    // stale ans in mode 1 settle, start pulse while busy
    set_ans(1, 0, 1, 1);
    stale_mode = 1;
    ready_pat = 4'b1111;
    xmask = 9'h033;
    busy_start_c = 10;
    build_model();
    chk("pin_err_stale", exp_err, 4'b0010);
    run();
    chk("stale_pops", pops, 16);
    stale_mode = -1;
    busy_start_c = -1;
    idle_check("post_stale", 2);

    // reset during STREAM at word 5
    set_ans(1, 1, 1, 1);
    xmask = '0;
    stop_tag = 5;
    run();
    stop_tag = -1;
    chk("pre_rst_valid", res_valid, 1);
    chk("pre_rst_tag", res_tag, 5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", res_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.r_buf[i] != '0) nz++;
    chk("mrst_buf_cleared", nz, 0);
    step();
    step();
    rst = 1'b0;
    idle_check("post_mrst", 5);
    xmask = 9'h1C3;
    run();
    chk("rerun_pops", pops, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
